// File: rtl/imem_fetch_s.sv
// Parametrised synchronous instruction memory for the IF stage: one-cycle fetch
// with valid, PC tag and fault flags, plus stall, flush and a program-load write port.
module imem_fetch_s #(
   parameter int                 ADDR_W   = 10,
   parameter int                 DATA_W   = 32,
   parameter logic [DATA_W-1:0]  NOP_WORD = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic              stall,
   input  logic              flush,
   input  logic [31:0]       pc,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] instr,
   output logic [31:0]       instr_pc,
   output logic              instr_valid,
   output logic              misalign,
   output logic              out_of_range
);

   localparam int DEPTH = 2 ** ADDR_W;

   // NOTE: the array is filled with NOP_WORD at elaboration and deliberately has no
   // reset; clearing memory on rst would be unsynthesizable as block RAM and would
   // also wipe a loaded program.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

   logic [ADDR_W-1:0] idx;
   logic              misalign_c;
   logic              out_of_range_c;

   assign idx        = pc[ADDR_W+1:2];
   assign misalign_c = |pc[1:0];
   // Shifting by ADDR_W+2 yields zero when ADDR_W=30, so no special case is needed.
   assign out_of_range_c = (pc >> (ADDR_W + 2)) != 32'd0;

   // Write port: independent of stall/flush, blocked only by rst.
   always_ff @(posedge clk) begin
      if (load_we && !rst)
         mem[load_addr] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr        <= NOP_WORD;
         instr_pc     <= 32'd0;
         instr_valid  <= 1'b0;
         misalign     <= 1'b0;
         out_of_range <= 1'b0;
      end else if (flush) begin
         instr        <= NOP_WORD;
         instr_pc     <= pc;
         instr_valid  <= 1'b0;
         misalign     <= 1'b0;
         out_of_range <= 1'b0;
      end else if (stall) begin
         instr        <= instr;
         instr_pc     <= instr_pc;
         instr_valid  <= instr_valid;
         misalign     <= misalign;
         out_of_range <= out_of_range;
      end else if (fetch_en && !load_we) begin
         instr_pc     <= pc;
         instr_valid  <= 1'b1;
         misalign     <= misalign_c;
         out_of_range <= out_of_range_c;
         instr        <= (misalign_c || out_of_range_c) ? NOP_WORD : mem[idx];
      end else begin
         // Idle or load cycle: bubble, instr_pc keeps its last tag.
         instr        <= NOP_WORD;
         instr_valid  <= 1'b0;
         misalign     <= 1'b0;
         out_of_range <= 1'b0;
      end
   end

endmodule

// File: tb/tb_imem_fetch_s.sv
// Self-checking bench for imem_fetch_s: directed scenarios then random traffic, with
// two instances (ADDR_W=10 and ADDR_W=4) compared against a behavioural model.
module tb_imem_fetch_s;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] ipc;
      logic        valid;
      logic        mis;
      logic        oor;
      logic        pc_known;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, fetch_en, stall, flush, load_we;
   logic [31:0] pc;
   logic [9:0]  load_addr;
   logic [31:0] load_data;

   logic [31:0] instr_a, instr_pc_a, instr_b, instr_pc_b;
   logic        valid_a, mis_a, oor_a, valid_b, mis_b, oor_b;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [31:0] mem_a [1024];
   logic [31:0] mem_b [16];
   exp_t        exp_a, exp_b;

   always #5 clk = ~clk;

   imem_fetch_s #(.ADDR_W(10)) dut_a (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .flush(flush),
      .pc(pc), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .instr(instr_a), .instr_pc(instr_pc_a), .instr_valid(valid_a),
      .misalign(mis_a), .out_of_range(oor_a)
   );

   imem_fetch_s #(.ADDR_W(4)) dut_b (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall), .flush(flush),
      .pc(pc), .load_we(load_we), .load_addr(load_addr[3:0]), .load_data(load_data),
      .instr(instr_b), .instr_pc(instr_pc_b), .instr_valid(valid_b),
      .misalign(mis_b), .out_of_range(oor_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, want, $time);
      end
   endtask

   // Next-state prediction from the priority rules; word is the model memory read.
   function automatic exp_t predict(exp_t prev, longint unsigned depth, logic [31:0] word);
      exp_t e = prev;
      longint unsigned byte_pc = longint'(pc);
      if (rst) begin
         e = '{NOP, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
      end else if (flush) begin
         e = '{NOP, pc, 1'b0, 1'b0, 1'b0, 1'b1};
      end else if (stall) begin
         e = prev;
      end else if (fetch_en && !load_we) begin
         e.mis      = (pc % 4) != 0;
         e.oor      = byte_pc >= depth * 4;
         e.valid    = 1'b1;
         e.ipc      = pc;
         e.pc_known = 1'b1;
         e.instr    = (e.mis || e.oor) ? NOP : word;
      end else begin
         e.instr    = NOP;
         e.valid    = 1'b0;
         e.mis      = 1'b0;
         e.oor      = 1'b0;
         e.pc_known = 1'b0;
      end
      return e;
   endfunction

   task automatic step();
      logic [31:0] wa, wb;
      wa = (pc / 4 < 1024) ? mem_a[pc / 4] : NOP;
      wb = (pc / 4 < 16)   ? mem_b[pc / 4] : NOP;
      exp_a = predict(exp_a, 1024, wa);
      exp_b = predict(exp_b, 16, wb);
      if (load_we && !rst) begin
         mem_a[load_addr]      = load_data;
         mem_b[load_addr % 16] = load_data;
      end
      @(posedge clk);
      #1;
      check("a.instr", instr_a, exp_a.instr);
      check("a.valid", 32'(valid_a), 32'(exp_a.valid));
      check("a.misalign", 32'(mis_a), 32'(exp_a.mis));
      check("a.out_of_range", 32'(oor_a), 32'(exp_a.oor));
      if (exp_a.pc_known) check("a.instr_pc", instr_pc_a, exp_a.ipc);
      check("b.instr", instr_b, exp_b.instr);
      check("b.valid", 32'(valid_b), 32'(exp_b.valid));
      check("b.misalign", 32'(mis_b), 32'(exp_b.mis));
      check("b.out_of_range", 32'(oor_b), 32'(exp_b.oor));
      if (exp_b.pc_known) check("b.instr_pc", instr_pc_b, exp_b.ipc);
   endtask

   task automatic drive(input logic r, input logic fe, input logic st, input logic fl,
                        input logic [31:0] p, input logic we, input logic [9:0] la,
                        input logic [31:0] ld);
      rst = r; fetch_en = fe; stall = st; flush = fl; pc = p;
      load_we = we; load_addr = la; load_data = ld;
      step();
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 32'd0, 0, 10'd0, 32'd0);
   endtask

   task automatic fetch(input logic [31:0] p);
      drive(0, 1, 0, 0, p, 0, 10'd0, 32'd0);
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      drive(0, 0, 0, 0, 32'd0, 1, a, d);
   endtask

   logic [31:0] prog [5] = '{32'h001a8193, 32'h00250213, 32'h00330313,
                              32'h00a183b3, 32'h004a8433};

   initial begin
      for (int i = 0; i < 1024; i++) mem_a[i] = NOP;
      for (int i = 0; i < 16; i++)   mem_b[i] = NOP;
      exp_a = '{NOP, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_b = exp_a;

      // Reset and program load, then sequential fetches.
      drive(1, 0, 0, 0, 32'd0, 0, 10'd0, 32'd0);
      drive(1, 0, 0, 0, 32'd0, 0, 10'd0, 32'd0);
      for (int i = 0; i < 5; i++) load(10'(i), prog[i]);
      for (int i = 0; i < 6; i++) fetch(32'(i * 4));
      check("plan1.last_nop", instr_a, NOP);

      // Stall holds outputs while the array is rewritten underneath.
      fetch(32'd4);
      drive(0, 1, 1, 0, 32'd8, 0, 10'd0, 32'd0);
      drive(0, 0, 1, 0, 32'd8, 1, 10'd1, 32'hDEADBEEF);
      drive(0, 1, 1, 0, 32'd12, 0, 10'd0, 32'd0);
      check("plan2.held", instr_a, 32'h00250213);
      fetch(32'd4);
      check("plan2.new_word", instr_a, 32'hDEADBEEF);

      // Flush beats stall and fetch.
      drive(0, 1, 1, 1, 32'd8, 0, 10'd0, 32'd0);
      check("plan3.flush_valid", 32'(valid_a), 32'd0);

      // Fault flags.
      fetch(32'h6);
      fetch(32'h1000);
      check("plan4.oor", 32'(oor_a), 32'd1);
      fetch(32'hFFFF_FFFC);

      // Reset discards a same-cycle load.
      drive(1, 0, 0, 0, 32'd0, 1, 10'd7, 32'h12345678);
      fetch(32'h1C);
      check("plan5.discarded", instr_a, NOP);

      // Small-array boundary: last word, then first out-of-range address.
      load(10'd15, 32'hCAFE_0015);
      fetch(32'h3C);
      check("plan6.last_word", instr_b, 32'hCAFE_0015);
      fetch(32'h40);
      check("plan6.oor", 32'(oor_b), 32'd1);
      idle();

      // Random traffic.
      for (int n = 0; n < 2000; n++) begin
         logic [31:0] p;
         int unsigned sel = $urandom_range(0, 99);
         if (sel < 60)      p = 32'($urandom_range(0, 63)) * 4;
         else if (sel < 75) p = 32'($urandom_range(0, 255));
         else if (sel < 90) p = 32'($urandom_range(0, 32'h1100));
         else               p = $urandom;
         drive($urandom_range(0, 99) < 2, 1'($urandom), $urandom_range(0, 99) < 20,
               $urandom_range(0, 99) < 10, p, $urandom_range(0, 99) < 15,
               10'($urandom_range(0, 63)), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imem_fetch_s.md
Name: imem_fetch_s

Overview:
Parametrised synchronous instruction memory with a fetch-side handshake. It supersedes the fixed 1024x32 ROM used by the pipeline's IF stage. It takes a byte PC, returns the instruction word one cycle later with valid, PC tag and fault flags, and supports stall, flush and a write port for runtime program loading. It sits between the PC register and the IF/ID pipeline register.

Parameters:
ADDR_W, 10, word-index width; DEPTH = 2**ADDR_W words
DATA_W, 32, instruction word width
NOP_WORD, 32'h00000013, word returned on bubble/fault (addi x0,x0,0)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
fetch_en  in  1  request fetch at pc this cycle
stall  in  1  hold all outputs (IF/ID stall)
flush  in  1  kill the in-flight fetch (branch/jump taken)
pc  in  32  byte address of the fetch
load_we  in  1  program-load write strobe
load_addr  in  ADDR_W  word index for the load write
load_data  in  DATA_W  word to write
instr  out  DATA_W  fetched instruction
instr_pc  out  32  pc that produced instr
instr_valid  out  1  instr is a real fetch result
misalign  out  1  fetch pc[1:0] != 0
out_of_range  out  1  fetch pc[31:ADDR_W+2] != 0

Behaviour:
- Clock is clk. Reset is rst: one clock, synchronous, active-high. All outputs register on posedge clk.
- Memory array is DEPTH x DATA_W and is initialised to NOP_WORD at elaboration. rst does not clear the array.
- Reset values: instr=NOP_WORD, instr_pc=0, instr_valid=0, misalign=0, out_of_range=0.
- Output priority per posedge, highest first:
  1. rst: reset values. Any load write in the same cycle is discarded.
  2. flush: instr=NOP_WORD, instr_valid=0, flags=0, instr_pc=pc. Flush overrides stall.
  3. stall: all outputs hold previous values, even if the array is written underneath.
  4. load_we: instr=NOP_WORD, instr_valid=0, flags=0. The load consumes the fetch slot, so a same-cycle fetch_en is ignored.
  5. fetch_en: see fetch rules below.
  6. Idle: instr=NOP_WORD, instr_valid=0, flags=0.
- Fetch rules:
  - idx = pc[ADDR_W+1:2].
  - misalign = |pc[1:0].
  - out_of_range = |pc[31:ADDR_W+2], taken as 0 when ADDR_W=30.
  - On either fault: instr=NOP_WORD, instr_valid=1, the fault flag(s) set, instr_pc=pc. Valid=1 lets the downstream stage raise a trap.
  - No fault: instr=mem[idx], instr_valid=1, instr_pc=pc.
- Write side:
  - mem[load_addr] <= load_data when load_we && !rst.
  - The write is independent of stall and flush.
  - It is visible to fetches starting the next cycle or later.
- Latency: exactly 1 cycle from fetch_en to instr_valid. Back-to-back fetches give one result per cycle.
- Read-during-write on the same address cannot occur, because load_we blocks fetch.
- Wrap-around: none. A pc beyond DEPTH*4 always flags out_of_range and never aliases.

Test Plan:
1. Reset then 5 load writes: idx0..4 = 001a8193, 00250213, 00330313, 00a183b3, 004a8433. Then fetch pc=0,4,8,12,16,20 -> instr follows 1 cycle later in that order, with 00000013 at pc=20; instr_valid=1 each cycle; instr_pc matches.
2. Fetch pc=4 with stall=1 for 3 cycles after the result appears, plus a load write to idx1=DEADBEEF during the stall -> outputs stay 00250213 / instr_pc=4 for 3 cycles; the next fetch of pc=4 returns DEADBEEF.
3. fetch_en, stall and flush all high together -> instr=00000013, instr_valid=0 next cycle; flush wins.
4. Fetch pc=0x6 -> misalign=1, instr=00000013, instr_valid=1. Fetch pc=0x1000 with ADDR_W=10 -> out_of_range=1, instr=00000013, instr_valid=1.
5. rst asserted in the same cycle as load_we to idx7=12345678 -> outputs at reset values; a later fetch of pc=0x1C returns 00000013, so the write was discarded.
6. ADDR_W=4, DATA_W=32: fetch pc=0x3C -> mem[15]; pc=0x40 -> out_of_range=1.
